navigate: RTL and testbench
===========================

# navigate

Command responder for the maze solver's heading/move interface. Accepts single-cycle `strt_hdng` and `strt_mv` requests. For a heading request it holds until the heading loop reports `at_hdng`. For a move request it ramps forward speed up, then ramps it down when a stop condition occurs. Each completed command is acknowledged with a one-cycle `mv_cmplt` pulse. It sits between the solver state machine and the PID/motor-drive path.

## Interface
Parameters:
- `FRWRD_INC`, default 11'h018: speed step per `hdng_rdy`. Slow decel is 2×, fast decel is 4×.
- `MIN_FRWRD`, default 11'h0D0: speed loaded on move start.
- `MAX_FRWRD`, default 11'h2A0: speed saturation ceiling.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `strt_hdng`  in  1  start-heading request pulse
- `strt_mv`  in  1  start-move request pulse
- `stp_lft`  in  1  move stops on a new left opening
- `stp_rght`  in  1  move stops on a new right opening
- `hdng_rdy`  in  1  new heading sample valid; paces ramp steps
- `at_hdng`  in  1  heading error within tolerance
- `lft_opn`  in  1  left wall absent
- `rght_opn`  in  1  right wall absent
- `frwrd_opn`  in  1  path ahead clear
- `mv_cmplt`  out  1  one-cycle completion pulse
- `moving`  out  1  command in progress
- `en_fusion`  out  1  enable gyro/IR fusion
- `frwrd_spd`  out  11  unsigned forward speed

## Operation
States and transitions:
- `IDLE`
  - `strt_hdng` → `HEADING`.
  - `strt_mv` → `RAMP_UP`, with `frwrd_spd` loaded to `MIN_FRWRD`.
  - If both arrive together, `strt_hdng` wins.
  - Requests arriving in any other state are ignored.
- `HEADING`
  - `frwrd_spd` = 0 and `moving` = 1.
  - `at_hdng` → `IDLE` and pulse `mv_cmplt`.
- `RAMP_UP`
  - On each `hdng_rdy`: `frwrd_spd` += `FRWRD_INC`, saturating at `MAX_FRWRD`. Overflow never wraps.
  - Priority in this state, highest first:
    1. `!frwrd_opn` → `DEC_FAST`.
    2. (`stp_lft` & `lft_rise`) or (`stp_rght` & `rght_rise`) → `DEC_SLOW`.
- `DEC_FAST`
  - On each `hdng_rdy`: `frwrd_spd` −= 4·`FRWRD_INC`, clamping at 0.
- `DEC_SLOW`
  - On each `hdng_rdy`: `frwrd_spd` −= 2·`FRWRD_INC`, clamping at 0.
  - `!frwrd_opn` still escalates to `DEC_FAST`.
- Leaving either decel state:
  - `frwrd_spd` == 0 → `IDLE` and pulse `mv_cmplt`.

Rules:
- `lft_rise` = `lft_opn` & ~`lft_opn_ff`; `rght_rise` is formed the same way.
  - The `_ff` history flops update every cycle in every state.
  - They reset to 1, so an opening already present at reset produces no edge.
- `moving` = 1 in every state except `IDLE`.
- `en_fusion` = 1 when `frwrd_spd` > `MAX_FRWRD`>>1.
- The decrement comparison uses 12-bit arithmetic before clamping, so there is no underflow.

## Timing
- Reset values: `frwrd_spd` = 0, `mv_cmplt` = 0, `moving` = 0, `en_fusion` = 0; state = `IDLE`.
- Request latency: `moving` rises the cycle after the request is sampled.
- `mv_cmplt` is registered:
  - high for exactly the first cycle back in `IDLE`;
  - a new request may be accepted in that same cycle.
- Speed changes only on `hdng_rdy` cycles, and the update is visible the next cycle.
- A stop condition sampled with `hdng_rdy` high: the state changes and the first decrement is applied on the following `hdng_rdy`.
- Reset mid-command: everything returns to reset values immediately, with no `mv_cmplt`.

## Configuration
- `NAV_OPN_SYNC_EN` defined:
  - `lft_opn`, `rght_opn` and `frwrd_opn` pass through a two-flop synchronizer before all use.
  - The synchronizer flops reset to 1.
  - Adds 2 cycles of stop-detection latency.
- `NAV_OPN_SYNC_EN` undefined: the inputs are used directly.

## Structure
- Shared package `nav_pkg` holds:
  - state enum `nav_state_t`;
  - decel multiplier constants (`FAST_DEC_SHIFT` = 2, `SLOW_DEC_SHIFT` = 1).
- One natural sub-module: `nav_spd_ramp`.
  - Contains the saturating/clamping speed register.
  - Inputs: load, inc, dec-select, `hdng_rdy`.
- Edge detection and the optional synchronizer stay inline.

## Test plan
- `strt_hdng`, then `at_hdng` 10 cycles later → `moving` high for 10 cycles, then a single `mv_cmplt` pulse; `frwrd_spd` stays 0.
- `strt_mv` with `hdng_rdy` every 4 cycles and `frwrd_opn` = 1 → speed steps 0x0D0, 0x0E8, … and saturates at 0x2A0; `en_fusion` rises once speed > 0x150.
- At speed 0x2A0, drop `frwrd_opn` → speed decrements by 0x060 per `hdng_rdy`, clamps to 0, then `mv_cmplt`.
- `stp_lft` = 1 with `lft_opn` held 1 at move start → no stop; then toggle `lft_opn` 0→1 → `DEC_SLOW` with steps of 0x030.
- `strt_hdng` and `strt_mv` in the same cycle → `HEADING` taken; `strt_mv` issued during `HEADING` is ignored.
- Assert `rst_n` low mid-ramp → all outputs return to 0 asynchronously and no `mv_cmplt` pulse occurs. With `NAV_OPN_SYNC_EN` defined, the stop response is 2 cycles later.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared types and constants for the navigate command responder.
// The optional opening-input synchronizer is selected with NAV_OPN_SYNC_EN.
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADING,
        RAMP_UP,
        DEC_FAST,
        DEC_SLOW
    } nav_state_t;

    localparam int FAST_DEC_SHIFT = 2;
    localparam int SLOW_DEC_SHIFT = 1;
    localparam int SPD_W          = 11;

endpackage

// File: rtl/navigate_if.sv
// Command/status bundle between the maze solver and navigate.
// Solver side is master, navigate side is slave.
interface navigate_if;
    import nav_pkg::*;

    logic             strt_hdng;
    logic             strt_mv;
    logic             stp_lft;
    logic             stp_rght;
    logic             hdng_rdy;
    logic             at_hdng;
    logic             lft_opn;
    logic             rght_opn;
    logic             frwrd_opn;
    logic             mv_cmplt;
    logic             moving;
    logic             en_fusion;
    logic [SPD_W-1:0] frwrd_spd;

    modport master (
        output strt_hdng, strt_mv, stp_lft, stp_rght,
        output hdng_rdy, at_hdng,
        output lft_opn, rght_opn, frwrd_opn,
        input  mv_cmplt, moving, en_fusion, frwrd_spd
    );

    modport slave (
        input  strt_hdng, strt_mv, stp_lft, stp_rght,
        input  hdng_rdy, at_hdng,
        input  lft_opn, rght_opn, frwrd_opn,
        output mv_cmplt, moving, en_fusion, frwrd_spd
    );

endinterface

// File: rtl/nav_spd_ramp.sv
// Forward speed register: load, saturating ramp-up, clamping ramp-down.
// Every step is paced by hdng_rdy; load takes priority.
module nav_spd_ramp
    import nav_pkg::*;
#(
    parameter logic [SPD_W-1:0] FRWRD_INC = 11'h018,
    parameter logic [SPD_W-1:0] MIN_FRWRD = 11'h0D0,
    parameter logic [SPD_W-1:0] MAX_FRWRD = 11'h2A0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             dec_fast,
    input  logic             hdng_rdy,
    output logic [SPD_W-1:0] spd
);

    logic [SPD_W:0]   step;
    logic [SPD_W:0]   sum;
    logic [SPD_W:0]   diff;
    logic [SPD_W-1:0] spd_nxt;

    // One extra bit so overflow saturates and underflow clamps.
    assign step = dec_fast ? ({1'b0, FRWRD_INC} << FAST_DEC_SHIFT)
                           : ({1'b0, FRWRD_INC} << SLOW_DEC_SHIFT);
    assign sum  = {1'b0, spd} + {1'b0, FRWRD_INC};
    assign diff = {1'b0, spd} - step;

    always_comb begin
        spd_nxt = spd;
        if (load)
            spd_nxt = MIN_FRWRD;
        else if (hdng_rdy && inc)
            spd_nxt = (sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : sum[SPD_W-1:0];
        else if (hdng_rdy && dec)
            spd_nxt = diff[SPD_W] ? '0 : diff[SPD_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spd <= '0;
        else
            spd <= spd_nxt;
    end

endmodule

// File: rtl/navigate.sv
// Heading/move command responder between the solver FSM and the PID path.
// Define NAV_OPN_SYNC_EN to double-flop the wall-opening inputs.
module navigate
    import nav_pkg::*;
#(
    parameter logic [SPD_W-1:0] FRWRD_INC = 11'h018,
    parameter logic [SPD_W-1:0] MIN_FRWRD = 11'h0D0,
    parameter logic [SPD_W-1:0] MAX_FRWRD = 11'h2A0
) (
    input  logic       clk,
    input  logic       rst_n,
    navigate_if.slave  nav
);

    nav_state_t       state;
    logic             lft_use;
    logic             rght_use;
    logic             frwrd_use;
    logic             lft_ff;
    logic             rght_ff;
    logic             lft_rise;
    logic             rght_rise;
    logic             stop_req;
    logic             spd_load;
    logic             mv_cmplt;
    logic             moving;
    logic [SPD_W-1:0] spd;

`ifdef NAV_OPN_SYNC_EN
    logic [1:0] lft_sync;
    logic [1:0] rght_sync;
    logic [1:0] frwrd_sync;

    // Reset to "open" so nothing looks like a fresh edge or a blockage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_sync   <= 2'b11;
            rght_sync  <= 2'b11;
            frwrd_sync <= 2'b11;
        end else begin
            lft_sync   <= {lft_sync[0], nav.lft_opn};
            rght_sync  <= {rght_sync[0], nav.rght_opn};
            frwrd_sync <= {frwrd_sync[0], nav.frwrd_opn};
        end
    end

    assign lft_use   = lft_sync[1];
    assign rght_use  = rght_sync[1];
    assign frwrd_use = frwrd_sync[1];
`else
    assign lft_use   = nav.lft_opn;
    assign rght_use  = nav.rght_opn;
    assign frwrd_use = nav.frwrd_opn;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ff  <= 1'b1;
            rght_ff <= 1'b1;
        end else begin
            lft_ff  <= lft_use;
            rght_ff <= rght_use;
        end
    end

    assign lft_rise  = lft_use & ~lft_ff;
    assign rght_rise = rght_use & ~rght_ff;
    assign stop_req  = (nav.stp_lft & lft_rise) |
                       (nav.stp_rght & rght_rise);
    assign spd_load  = (state == IDLE) & ~nav.strt_hdng & nav.strt_mv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mv_cmplt <= 1'b0;
            moving   <= 1'b0;
        end else begin
            mv_cmplt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (nav.strt_hdng) begin
                        state  <= HEADING;
                        moving <= 1'b1;
                    end else if (nav.strt_mv) begin
                        state  <= RAMP_UP;
                        moving <= 1'b1;
                    end
                end
                HEADING: begin
                    if (nav.at_hdng) begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!frwrd_use)
                        state <= DEC_FAST;
                    else if (stop_req)
                        state <= DEC_SLOW;
                end
                DEC_SLOW: begin
                    if (spd == '0) begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end else if (!frwrd_use) begin
                        state <= DEC_FAST;
                    end
                end
                DEC_FAST: begin
                    if (spd == '0) begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    moving <= 1'b0;
                end
            endcase
        end
    end

    nav_spd_ramp #(
        .FRWRD_INC (FRWRD_INC),
        .MIN_FRWRD (MIN_FRWRD),
        .MAX_FRWRD (MAX_FRWRD)
    ) u_ramp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (spd_load),
        .inc      (state == RAMP_UP),
        .dec      ((state == DEC_FAST) || (state == DEC_SLOW)),
        .dec_fast (state == DEC_FAST),
        .hdng_rdy (nav.hdng_rdy),
        .spd      (spd)
    );

    assign nav.frwrd_spd = spd;
    assign nav.mv_cmplt  = mv_cmplt;
    assign nav.moving    = moving;
    assign nav.en_fusion = spd > (MAX_FRWRD >> 1);

endmodule

// File: tb/tb_navigate.sv
// Scoreboarded random/directed bench for navigate.
// Build with NAV_OPN_SYNC_EN to check the synchronized variant.
module tb_navigate;

    localparam int INC = 'h018;
    localparam int MIN = 'h0D0;
    localparam int MAX = 'h2A0;

    typedef struct {
        int mov;
        int spd;
        int fus;
        int cmp;
    } exp_t;

    logic clk;
    logic rst_n;
    navigate_if nav_if ();

    navigate #(
        .FRWRD_INC (11'(INC)),
        .MIN_FRWRD (11'(MIN)),
        .MAX_FRWRD (11'(MAX))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .nav   (nav_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // Reference model: phase 0 idle, 1 heading, 2 accelerate,
    // 3 gentle brake, 4 hard brake.
    int m_ph   = 0;
    int m_spd  = 0;
    int m_lp   = 1;
    int m_rp   = 1;
    int m_l[2] = '{1, 1};
    int m_r[2] = '{1, 1};
    int m_f[2] = '{1, 1};

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endfunction

    task automatic model_step();
        int lu, ru, fu, lr, rr, cm, ns, stp;
        exp_t e;
        if (!rst_n) begin
            m_ph = 0; m_spd = 0; m_lp = 1; m_rp = 1;
            m_l = '{1, 1}; m_r = '{1, 1}; m_f = '{1, 1};
            e = '{0, 0, 0, 0};
            sb_q.push_back(e);
            return;
        end
`ifdef NAV_OPN_SYNC_EN
        lu = m_l[1]; ru = m_r[1]; fu = m_f[1];
        m_l = '{int'(nav_if.lft_opn), m_l[0]};
        m_r = '{int'(nav_if.rght_opn), m_r[0]};
        m_f = '{int'(nav_if.frwrd_opn), m_f[0]};
`else
        lu = int'(nav_if.lft_opn);
        ru = int'(nav_if.rght_opn);
        fu = int'(nav_if.frwrd_opn);
`endif
        lr = (lu == 1 && m_lp == 0) ? 1 : 0;
        rr = (ru == 1 && m_rp == 0) ? 1 : 0;
        m_lp = lu; m_rp = ru;
        cm = 0;
        ns = m_spd;
        case (m_ph)
            0: begin
                if (nav_if.strt_hdng) m_ph = 1;
                else if (nav_if.strt_mv) begin
                    m_ph = 2; ns = MIN;
                end
            end
            1: if (nav_if.at_hdng) begin m_ph = 0; cm = 1; end
            2: begin
                if (nav_if.hdng_rdy)
                    ns = (m_spd + INC > MAX) ? MAX : m_spd + INC;
                if (fu == 0) m_ph = 4;
                else if ((nav_if.stp_lft && lr == 1) ||
                         (nav_if.stp_rght && rr == 1)) m_ph = 3;
            end
            default: begin
                stp = (m_ph == 4) ? 4 * INC : 2 * INC;
                if (nav_if.hdng_rdy)
                    ns = (m_spd >= stp) ? m_spd - stp : 0;
                if (m_spd == 0) begin m_ph = 0; cm = 1; end
                else if (m_ph == 3 && fu == 0) m_ph = 4;
            end
        endcase
        m_spd = ns;
        e.mov = (m_ph != 0) ? 1 : 0;
        e.spd = m_spd;
        e.fus = (m_spd > MAX / 2) ? 1 : 0;
        e.cmp = cm;
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: every cycle the DUT presents a status word to compare.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("moving", int'(nav_if.moving), e.mov);
            chk("frwrd_spd", int'(nav_if.frwrd_spd), e.spd);
            chk("en_fusion", int'(nav_if.en_fusion), e.fus);
            chk("mv_cmplt", int'(nav_if.mv_cmplt), e.cmp);
        end
    end

    int cyc    = 0;
    int hr_per = 4;
    bit hr_rnd = 0;

    task automatic step();
        cyc++;
        if (hr_rnd) nav_if.hdng_rdy = ($urandom_range(0, 2) == 0);
        else        nav_if.hdng_rdy = (cyc % hr_per == 0);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_mv();
        nav_if.strt_mv = 1'b1;
        step();
        nav_if.strt_mv = 1'b0;
    endtask

    task automatic wait_idle(int lim);
        for (int i = 0; i < lim; i++) begin
            if (m_ph == 0) return;
            step();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle timeout at %0t: phase %0d expected 0",
                 $time, m_ph);
    endtask

    task automatic zero_chk(string tag);
        chk({tag, "_moving"}, int'(nav_if.moving), 0);
        chk({tag, "_spd"}, int'(nav_if.frwrd_spd), 0);
        chk({tag, "_fusion"}, int'(nav_if.en_fusion), 0);
        chk({tag, "_cmplt"}, int'(nav_if.mv_cmplt), 0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 zero_chk("async_rst");
        nav_if.strt_hdng = 1'b0;
        nav_if.strt_mv   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        nav_if.strt_hdng = 1'b0;
        nav_if.strt_mv   = 1'b0;
        nav_if.stp_lft   = 1'b0;
        nav_if.stp_rght  = 1'b0;
        nav_if.hdng_rdy  = 1'b0;
        nav_if.at_hdng   = 1'b0;
        nav_if.lft_opn   = 1'b1;
        nav_if.rght_opn  = 1'b1;
        nav_if.frwrd_opn = 1'b1;
        #1 zero_chk("reset");
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Heading: completes 10 cycles after the request.
        nav_if.strt_hdng = 1'b1;
        step();
        nav_if.strt_hdng = 1'b0;
        repeat (9) step();
        nav_if.at_hdng = 1'b1;
        step();
        nav_if.at_hdng = 1'b0;
        wait_idle(20);
        repeat (3) step();

        // Ramp to saturation then hard brake.
        pulse_mv();
        for (int i = 0; i < 300 && m_spd != MAX; i++) step();
        chk("saturated", m_spd, MAX);
        repeat (8) step();
        nav_if.frwrd_opn = 1'b0;
        wait_idle(200);
        nav_if.frwrd_opn = 1'b1;
        repeat (4) step();

        // Pre-existing left opening is not a stop; a new one is.
        nav_if.stp_lft = 1'b1;
        pulse_mv();
        repeat (20) step();
        nav_if.lft_opn = 1'b0;
        repeat (2) step();
        nav_if.lft_opn = 1'b1;
        wait_idle(200);
        nav_if.stp_lft = 1'b0;
        repeat (4) step();

        // Simultaneous requests; a move during heading is ignored.
        nav_if.strt_hdng = 1'b1;
        nav_if.strt_mv   = 1'b1;
        step();
        nav_if.strt_hdng = 1'b0;
        nav_if.strt_mv   = 1'b0;
        repeat (3) step();
        pulse_mv();
        repeat (3) step();
        nav_if.at_hdng = 1'b1;
        step();
        nav_if.at_hdng = 1'b0;
        repeat (4) step();

        // Reset in the middle of a ramp.
        pulse_mv();
        repeat (30) step();
        async_reset();

        // Random traffic.
        hr_rnd = 1;
        for (int i = 0; i < 4000; i++) begin
            nav_if.strt_hdng = ($urandom_range(0, 15) == 0);
            nav_if.strt_mv   = ($urandom_range(0, 5) == 0);
            nav_if.at_hdng   = ($urandom_range(0, 11) == 0);
            nav_if.stp_lft   = ($urandom_range(0, 1) == 0);
            nav_if.stp_rght  = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0)
                nav_if.lft_opn = ~nav_if.lft_opn;
            if ($urandom_range(0, 9) == 0)
                nav_if.rght_opn = ~nav_if.rght_opn;
            if ($urandom_range(0, 39) == 0)
                nav_if.frwrd_opn = ~nav_if.frwrd_opn;
            if ($urandom_range(0, 799) == 0)
                async_reset();
            else
                step();
        end
        nav_if.strt_hdng = 1'b0;
        nav_if.strt_mv   = 1'b0;
        nav_if.frwrd_opn = 1'b0;
        nav_if.at_hdng   = 1'b1;
        wait_idle(200);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
